// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: reads the flattened code image by PC into a small prefetch FIFO
// and hands {pc, inst} to decode over valid/ready. Optional `IFQ_BYPASS_EN enables empty-FIFO bypass.
module ifetch_queue #(
  parameter int          IMEM_WORDS = 1024,
  parameter int          FQ_DEPTH   = 4,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic                    clk,
  input  logic [1:0]              rst_n,
  input  logic [32*IMEM_WORDS-1:0] input_code,
  input  logic                    redirect_valid,
  input  logic [31:0]             redirect_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_inst,
  output logic [31:0]             out_pc,
  output logic                    halted
);

  localparam int IDX_W = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  // Only the P encoding (2'b10) releases reset; N, O and 2'b11 all hold it.
  logic rst_ok;
  assign rst_ok = (rst_n == 2'b10);

  state_t             state_reg, state_next;
  logic [29:0]        fetch_wa_reg, fetch_wa_next;
  logic [PTR_W-1:0]   rd_ptr_reg, wr_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [31:0]        last_pc_reg, last_inst_reg;
  logic [29:0]        wa_mem   [FQ_DEPTH];
  logic [31:0]        inst_mem [FQ_DEPTH];

  logic [IDX_W-1:0]   fetch_idx;
  logic [31:0]        fetch_word;
  logic               in_range, halt_hit, fifo_empty, fifo_full;
  logic               pop, push, fetch_en, bypass, flush;
  logic               unused_low_bits;

  assign unused_low_bits = &{1'b0, redirect_pc[1:0]};

  assign fetch_idx  = fetch_wa_reg[IDX_W-1:0];
  assign fetch_word = input_code[{fetch_idx, 5'b0} +: 32];
  // Range test comes first so an aliased index never reaches the FIFO.
  assign in_range   = (fetch_wa_reg < 30'(IMEM_WORDS));
  assign halt_hit   = !in_range || (fetch_word == 32'h0);
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CNT_W'(FQ_DEPTH));
  assign flush      = redirect_valid && (state_reg != BOOT);
  assign pop        = !fifo_empty && out_ready;
  assign fetch_en   = (state_reg == RUN) && !redirect_valid && (!fifo_full || pop);

`ifdef IFQ_BYPASS_EN
  assign bypass = (state_reg == RUN) && fifo_empty && out_ready && !redirect_valid && !halt_hit;
`else
  assign bypass = 1'b0;
`endif

  assign push = fetch_en && !halt_hit && !bypass;

  always_comb begin
    out_valid = !fifo_empty || bypass;
    out_pc    = last_pc_reg;
    out_inst  = last_inst_reg;
    if (!fifo_empty) begin
      out_pc   = {wa_mem[rd_ptr_reg], 2'b00};
      out_inst = inst_mem[rd_ptr_reg];
    end else if (bypass) begin
      out_pc   = {fetch_wa_reg, 2'b00};
      out_inst = fetch_word;
    end
  end

  assign halted = (state_reg == HALT);

  always_comb begin
    state_next    = state_reg;
    fetch_wa_next = fetch_wa_reg;
    case (state_reg)
      BOOT: state_next = RUN;
      RUN: begin
        if (fetch_en) begin
          if (halt_hit) state_next = HALT;
          else          fetch_wa_next = fetch_wa_reg + 30'd1;
        end
      end
      default: ;
    endcase
    if (flush) begin
      state_next    = RUN;
      fetch_wa_next = redirect_pc[31:2];
    end
  end

  always_ff @(posedge clk or negedge rst_ok) begin
    if (!rst_ok) begin
      state_reg     <= BOOT;
      fetch_wa_reg  <= RESET_PC[31:2];
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      last_pc_reg   <= 32'h0;
      last_inst_reg <= NOP;
    end else begin
      state_reg    <= state_next;
      fetch_wa_reg <= fetch_wa_next;
      // A pop in the redirect cycle still completes, so the held output tracks it.
      if (pop) begin
        last_pc_reg   <= {wa_mem[rd_ptr_reg], 2'b00};
        last_inst_reg <= inst_mem[rd_ptr_reg];
      end else if (bypass) begin
        last_pc_reg   <= {fetch_wa_reg, 2'b00};
        last_inst_reg <= fetch_word;
      end
      if (flush) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wa_mem[wr_ptr_reg]   <= fetch_wa_reg;
      inst_mem[wr_ptr_reg] <= fetch_word;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized scoreboard bench for ifetch_queue: a queue-level fetch model predicts every
// presented beat; a negedge monitor compares DUT outputs against the model.
module tb_ifetch_queue;
  localparam int IW = 32;
  localparam int D  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic               clk = 1'b0;
  logic [1:0]         rst_n = 2'b00;
  logic [32*IW-1:0]   code = '0;
  logic               redirect_valid = 1'b0;
  logic [31:0]        redirect_pc = '0;
  logic               out_valid, out_ready = 1'b0, halted;
  logic [31:0]        out_inst, out_pc;
  logic               rst_ok_tb;

  ifetch_queue #(.IMEM_WORDS(IW), .FQ_DEPTH(D), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .input_code(code),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .halted(halted)
  );

  always #5 clk = ~clk;
  assign rst_ok_tb = (rst_n == 2'b10);

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected FIFO contents as a queue of {pc, inst}.
  logic [63:0] mq[$];
  logic [31:0] m_pc;
  int          m_state;          // 0 boot, 1 run, 2 halt
  logic [63:0] m_last;
  int          since_rel;
  int          first_valid_cyc;
  logic [31:0] beat_pc[$];

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    if (pc[31:2] < 30'(IW)) return code[int'(pc[31:2])*32 +: 32];
    return 32'h0;
  endfunction

  function automatic bit bypass_now();
`ifdef IFQ_BYPASS_EN
    return m_state == 1 && mq.size() == 0 && out_ready && !redirect_valid && word_at(m_pc) != 0;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst_ok_tb) begin
    if (!rst_ok_tb) begin
      mq.delete();
      m_pc = 32'h0; m_state = 0; m_last = {32'h0, NOP};
      since_rel = 0;
    end else begin
      bit bp, pp;
      int occ;
      logic [31:0] w;
      since_rel++;
      bp = bypass_now();
      pp = (mq.size() > 0) && out_ready;
      occ = mq.size();
      if (m_state == 0) begin
        m_state = 1;
      end else if (redirect_valid) begin
        if (pp) m_last = mq[0];
        mq.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
        m_state = 1;
      end else begin
        if (pp) m_last = mq.pop_front();
        if (m_state == 1 && (occ < D || pp)) begin
          w = word_at(m_pc);
          if (w == 32'h0) m_state = 2;
          else begin
            if (bp) m_last = {m_pc, w};
            else    mq.push_back({m_pc, w});
            m_pc = m_pc + 32'd4;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_ok_tb) begin
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_halted", {31'b0, halted}, 32'd0);
      chk("rst_pc", out_pc, 32'h0);
      chk("rst_inst", out_inst, NOP);
    end else begin
      bit ev;
      logic [63:0] e;
      ev = (mq.size() > 0) || bypass_now();
      chk("valid", {31'b0, out_valid}, {31'b0, ev});
      chk("halted", {31'b0, halted}, {31'b0, m_state == 2});
      if (ev) begin
        e = (mq.size() > 0) ? mq[0] : {m_pc, word_at(m_pc)};
        if (first_valid_cyc < 0) first_valid_cyc = since_rel;
      end else begin
        e = m_last;
      end
      chk("out_pc", out_pc, e[63:32]);
      chk("out_inst", out_inst, e[31:0]);
      if (out_valid && out_ready) begin
        beat_pc.push_back(out_pc);
        $display("beat pc=%h inst=%h", out_pc, out_inst);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset(input logic [1:0] rv);
    @(posedge clk); #3;
    rst_n = rv;
    #1;
    chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("async_rst_halted", {31'b0, halted}, 32'd0);
    redirect_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 2'b10;
    beat_pc.delete();
    first_valid_cyc = -1;
  endtask

  task automatic straight_prog();
    code = '0;
    code[0*32 +: 32] = 32'h00A00413;
    code[1*32 +: 32] = 32'h00100313;
    code[2*32 +: 32] = 32'h00000013;
  endtask

  task automatic rand_prog(input int zero_pct);
    for (int k = 0; k < IW; k++) begin
      logic [31:0] w;
      w = $urandom | 32'h1;
      if ($urandom_range(99) < zero_pct) w = 32'h0;
      code[k*32 +: 32] = w;
    end
  endtask

  initial begin
    first_valid_cyc = -1;
    // Straight line, full-rate drain, halt at the zero word.
    straight_prog();
    out_ready = 1'b1;
    do_reset(2'b00);
    cyc(12);
    chk("p1_beats", beat_pc.size(), 3);
    for (int k = 0; k < 3 && k < beat_pc.size(); k++) chk("p1_pc", beat_pc[k], 32'(4 * k));
    chk("p1_halted", {31'b0, halted}, 32'd1);
`ifdef IFQ_BYPASS_EN
    chk("p1_first_cyc", first_valid_cyc, 1);
`else
    chk("p1_first_cyc", first_valid_cyc, 2);
`endif

    // Redirect out of HALT restarts at pc 0.
    redirect_pc = 32'h0; redirect_valid = 1'b1;
    cyc(1);
    redirect_valid = 1'b0;
    beat_pc.delete();
    cyc(10);
    chk("halt_redir_beats", beat_pc.size(), 3);
    if (beat_pc.size() > 0) chk("halt_redir_pc0", beat_pc[0], 32'h0);

    // Back-pressure: fill, hold, then in-order drain.
    rand_prog(0);
    code[8*32 +: 32] = 32'h0;
    out_ready = 1'b0;
    do_reset(2'b01);
    cyc(10);
    chk("bp_hold_pc", out_pc, 32'h0);
    chk("bp_no_beats", beat_pc.size(), 0);
    out_ready = 1'b1;
    cyc(15);
    chk("bp_beats", beat_pc.size(), 8);
    for (int k = 0; k < 8 && k < beat_pc.size(); k++) chk("bp_pc", beat_pc[k], 32'(4 * k));

    // Redirect while pc 8 is at the head: pc 8 dropped, next beat is 0x1C.
    rand_prog(0);
    out_ready = 1'b0;
    do_reset(2'b11);
    cyc(6);
    out_ready = 1'b1;
    cyc(2);
    out_ready = 1'b0;
    redirect_pc = 32'h1E; redirect_valid = 1'b1;
    cyc(1);
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    cyc(6);
    chk("redir_nbeats", {31'b0, beat_pc.size() >= 3}, 32'd1);
    if (beat_pc.size() >= 3) chk("redir_pc", beat_pc[2], 32'h1C);

    // Randomized traffic with redirects, range-end halts and mid-stream resets.
    for (int r = 0; r < 6; r++) begin
      rand_prog((r % 2 == 0) ? 0 : 8);
      do_reset(2'(r % 2));
      for (int c = 0; c < 250; c++) begin
        out_ready = ($urandom_range(3) != 0);
        redirect_valid = ($urandom_range(19) == 0);
        redirect_pc = $urandom_range(0, 4 * IW + 12);
        if ($urandom_range(149) == 0) begin
          do_reset(2'($urandom_range(0, 2) == 2 ? 3 : $urandom_range(0, 1)));
        end else begin
          cyc(1);
        end
      end
      redirect_valid = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
